vme_cmd_arbiter: RTL
====================

VME_CMD_ARBITER -- requirements
Module: vme_cmd_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of command requesters; legal range is NREQ >= 2.
REQ-002 Parameter MASK, default 32'h00A80000: constant ORed into every issued command word.
REQ-003 Parameter TIMEOUT, default 16'd1023: maximum WAIT_DONE cycles before an abort.
REQ-004 Port clk, in, 1: single clock; all logic is on the rising edge.
REQ-005 Port rst_n, in, 1: synchronous, active-low reset.
REQ-006 Port req, in, NREQ: bit i high means requester i has a pending command.
REQ-007 Port req_rnw, in, NREQ: bit i is 1 for a read and 0 for a write.
REQ-008 Port req_cmd, in, NREQ*32: flattened command words; requester i occupies bits [32i+31:32i].
REQ-009 Port req_dat, in, NREQ*32: flattened write data, packed the same way as req_cmd.
REQ-010 Port ack, out, NREQ: one-cycle completion pulse to the granted requester.
REQ-011 Port tout, out, NREQ: one-cycle timeout flag, coincident with ack.
REQ-012 Port rd_data, out, 16: read result, valid while any ack bit is high.
REQ-013 Port grant_id, out, $clog2(NREQ): index of the requester currently owned.
REQ-014 Port busy, out, 1: high in every state except IDLE.
REQ-015 Port start, out, 1: one-cycle issue strobe to the VME master.
REQ-016 Port vme_cmd_reg, out, 32: formatted command word to the VME master.
REQ-017 Port vme_dat_reg_in, out, 32: write data to the VME master.
REQ-018 Port vme_cmd_rd, in, 1: VME master is ready to accept a command.
REQ-019 Port vme_dat_wr, in, 1: VME master completion strobe.
REQ-020 Port vme_dat_reg_out, in, 32: VME read-back data; only bits [15:0] are used.

Function
REQ-021 The block SHALL implement a four-state FSM: IDLE, WAIT_RDY, WAIT_DONE, RELEASE. All outputs SHALL be registered.
REQ-022 IDLE with any req bit high: the block SHALL grant round-robin, searching from last_grant+1 modulo NREQ.
- On grant: latch rnw, cmd and dat of the winner; update grant_id and last_grant; go to WAIT_RDY.
REQ-023 WAIT_RDY with vme_cmd_rd high: on the next cycle the block SHALL drive start=1 for exactly one cycle, then go to WAIT_DONE.
- vme_cmd_reg = latched cmd | MASK, with bit25 set for a read or bit24 set for a write.
- vme_dat_reg_in = latched dat.
REQ-024 Whenever start=0, the block SHALL drive vme_cmd_reg=MASK and vme_dat_reg_in=0.
REQ-025 WAIT_DONE with vme_dat_wr high: the block SHALL register rd_data=vme_dat_reg_out[15:0] and pulse ack[grant_id] in the following cycle, which is RELEASE.
- For a write, rd_data SHALL be 16'h0000.
REQ-026 WAIT_DONE SHALL count cycles from 0. When the count reaches TIMEOUT without vme_dat_wr:
- next cycle is RELEASE with ack[grant_id]=1, tout[grant_id]=1 and rd_data=16'hFFFF.
REQ-027 If vme_dat_wr and the timeout terminal count occur in the same cycle, completion SHALL win and tout SHALL stay 0.
REQ-028 RELEASE SHALL last exactly one cycle and then go to IDLE.
- Requesters drop req on ack, so IDLE never re-grants a stale request.
REQ-029 Once granted, the latched command SHALL be issued even if req deasserts; req and data changes during a transaction SHALL be ignored.
REQ-030 vme_dat_wr outside WAIT_DONE SHALL be ignored.
REQ-031 Minimum latency, with req sampled in IDLE at edge k and vme_cmd_rd high: start in cycle k+2, ack one cycle after vme_dat_wr is sampled.

Reset
REQ-032 With rst_n=0 at a clock edge, outputs SHALL reset as follows:
- state=IDLE, start=0, vme_cmd_reg=MASK, vme_dat_reg_in=0.
- ack=0, tout=0, rd_data=0, busy=0, grant_id=0.
- last_grant=NREQ-1, so requester 0 has first priority; timeout counter=0.
REQ-033 Reset in any state, including mid-transaction, SHALL abort with no ack pulse.

Verification
REQ-034 Single read: req=01, rnw=1, cmd0=32'h00004000, vme_cmd_rd=1, vme_dat_wr 3 cycles after start with dat_out=32'h0000BEEF.
- Expect one start with vme_cmd_reg=32'h02A84000.
- Expect ack=01 and rd_data=16'hBEEF.
REQ-035 Single write: req=10, rnw=0, cmd1=32'h00001234, dat1=32'h00005A5A.
- Expect vme_cmd_reg=32'h01A81234 and vme_dat_reg_in=32'h00005A5A.
- Expect ack=10 and rd_data=0.
REQ-036 Both requesters held high for 4 transactions: grants SHALL alternate 0,1,0,1.
REQ-037 TIMEOUT=8, vme_dat_wr never asserted: ack and tout pulse together exactly 9 cycles after entering WAIT_DONE, with rd_data=16'hFFFF.
REQ-038 rst_n=0 asserted in WAIT_DONE: next cycle busy=0, vme_cmd_reg=MASK, no ack.
- The next request SHALL be granted to requester 0.
REQ-039 vme_dat_wr asserted on the same cycle as the timeout terminal count: ack=1, tout=0.

Source files
------------

// File: rtl/vme_cmd_arbiter.sv
// rtl/vme_cmd_arbiter.sv - round-robin command arbiter feeding a single VME master
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   req               per-requester pending command flags
//   req_rnw           per-requester direction, 1 = read, 0 = write
//   req_cmd, req_dat  flattened 32-bit command words / write data, requester i at [32i+31:32i]
//   ack, tout         one-cycle completion pulse and coincident timeout flag to the owner
//   rd_data           read result, valid while any ack bit is high
//   grant_id          index of the requester currently owning the master
//   busy              high whenever a transaction is in flight
//   start             one-cycle issue strobe to the VME master
//   vme_cmd_reg       formatted command word (idles at MASK)
//   vme_dat_reg_in    write data to the master (idles at zero)
//   vme_cmd_rd        master ready to accept a command
//   vme_dat_wr        master completion strobe
//   vme_dat_reg_out   master read-back data, low 16 bits used

module vme_cmd_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [31:0] MASK    = 32'h00A8_0000,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_rnw,
  input  logic [NREQ*32-1:0]        req_cmd,
  input  logic [NREQ*32-1:0]        req_dat,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           tout,
  output logic [15:0]               rd_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      start,
  output logic [31:0]               vme_cmd_reg,
  output logic [31:0]               vme_dat_reg_in,
  input  logic                      vme_cmd_rd,
  input  logic                      vme_dat_wr,
  input  logic [31:0]               vme_dat_reg_out
);

  localparam int              GW     = $clog2(NREQ);
  localparam logic [31:0]     RD_BIT = 32'h0200_0000;
  localparam logic [31:0]     WR_BIT = 32'h0100_0000;
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, WAIT_DONE, RELEASE} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic          rnw_q;
  logic [31:0]   cmd_q;
  logic [31:0]   dat_q;
  logic [15:0]   cnt;

  // Only the low half of the read-back word is returned.
  logic unused_rd_hi;
  assign unused_rd_hi = ^vme_dat_reg_out[31:16];

  logic [31:0] cmd_arr [NREQ];
  logic [31:0] dat_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cmd_arr[g] = req_cmd[32*g +: 32];
    assign dat_arr[g] = req_dat[32*g +: 32];
  end

  // Round-robin search starting just after the previous winner.
  logic          win_found;
  logic [GW-1:0] win_idx;

  always_comb begin
    int            cand;
    logic [GW-1:0] cand_g;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_g    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand   = (int'(last_grant) + i) % NREQ;
      cand_g = GW'(cand);
      if (!win_found && req[cand_g]) begin
        win_found = 1'b1;
        win_idx   = cand_g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      start          <= 1'b0;
      vme_cmd_reg    <= MASK;
      vme_dat_reg_in <= '0;
      ack            <= '0;
      tout           <= '0;
      rd_data        <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      last_grant     <= GW'(NREQ - 1);
      cnt            <= '0;
      rnw_q          <= 1'b0;
      cmd_q          <= '0;
      dat_q          <= '0;
    end else begin
      // Strobes default low so every pulse is exactly one cycle wide.
      start          <= 1'b0;
      vme_cmd_reg    <= MASK;
      vme_dat_reg_in <= '0;
      ack            <= '0;
      tout           <= '0;

      case (state)
        IDLE: begin
          if (win_found) begin
            rnw_q      <= req_rnw[win_idx];
            cmd_q      <= cmd_arr[win_idx];
            dat_q      <= dat_arr[win_idx];
            grant_id   <= win_idx;
            last_grant <= win_idx;
            busy       <= 1'b1;
            state      <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (vme_cmd_rd) begin
            start          <= 1'b1;
            vme_cmd_reg    <= cmd_q | MASK | (rnw_q ? RD_BIT : WR_BIT);
            vme_dat_reg_in <= dat_q;
            cnt            <= '0;
            state          <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          // Completion is tested first so it wins a tie with the terminal count.
          if (vme_dat_wr) begin
            rd_data <= rnw_q ? vme_dat_reg_out[15:0] : 16'h0000;
            ack     <= ONE << grant_id;
            state   <= RELEASE;
          end else if (cnt == TIMEOUT) begin
            rd_data <= 16'hFFFF;
            ack     <= ONE << grant_id;
            tout    <= ONE << grant_id;
            state   <= RELEASE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RELEASE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
